// File: rtl/mem_loader_pkg.sv
// Shared types for the boot-time program loader: FSM state encoding,
// error cause codes and the running-checksum step.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI  = 3'd0,
    S_LEN_LO  = 3'd1,
    S_DATA_HI = 3'd2,
    S_DATA_LO = 3'd3,
    S_CSUM    = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/mem_loader.sv
// Boot loader: assembles big-endian words from a UART byte stream, writes them
// to sequential RAM addresses and holds the CPU in reset until the frame verifies.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024,
  parameter int TIMEOUT = 1000000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_restart,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_w_addr,
  output logic [15:0]       o_w_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [1:0]        o_err_code
);

  localparam int              TO_W    = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [16:0]     DEPTH_L = 17'(DEPTH);

  state_e              state_r, state_s;
  logic [7:0]          byte_hi_r, byte_hi_s;
  logic [15:0]         len_r, len_s;
  logic [15:0]         idx_r, idx_s;
  logic [7:0]          csum_r, csum_s;
  logic [TO_W-1:0]     tmo_r, tmo_s;
  logic                we_r, we_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [15:0]         data_r, data_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                err_r, err_s;
  logic [1:0]          code_r, code_s;
  logic                tmo_active_s;

  assign o_we       = we_r;
  assign o_w_addr   = addr_r;
  assign o_w_data   = data_r;
  assign o_busy     = busy_r;
  assign o_done     = done_r;
  assign o_err      = err_r;
  assign o_err_code = code_r;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_s      = state_r;
    byte_hi_s    = byte_hi_r;
    len_s        = len_r;
    idx_s        = idx_r;
    csum_s       = csum_r;
    tmo_s        = '0;
    we_s         = 1'b0;
    addr_s       = addr_r;
    data_s       = data_r;
    busy_s       = busy_r;
    done_s       = done_r;
    err_s        = err_r;
    code_s       = code_r;
    tmo_active_s = 1'b0;

    if (i_restart) begin
      // A coincident byte is deliberately dropped.
      state_s = S_LEN_HI;
      len_s   = 16'd0;
      idx_s   = 16'd0;
      csum_s  = 8'd0;
      busy_s  = 1'b1;
      done_s  = 1'b0;
      err_s   = 1'b0;
      code_s  = ERR_NONE;
    end else begin
      case (state_r)
        S_LEN_HI: begin
          if (i_rx_valid) begin
            byte_hi_s = i_rx_data;
            csum_s    = csum_step(csum_r, i_rx_data);
            state_s   = S_LEN_LO;
          end else begin
            state_s = S_LEN_HI;
          end
        end
        S_LEN_LO: begin
          tmo_active_s = 1'b1;
          if (i_rx_valid) begin
            len_s  = {byte_hi_r, i_rx_data};
            csum_s = csum_step(csum_r, i_rx_data);
            if ({1'b0, len_s} > DEPTH_L) begin
              state_s = S_ERR;
              err_s   = 1'b1;
              code_s  = ERR_LEN;
            end else if (len_s == 16'd0) begin
              state_s = S_CSUM;
            end else begin
              state_s = S_DATA_HI;
            end
          end else begin
            state_s = S_LEN_LO;
          end
        end
        S_DATA_HI: begin
          tmo_active_s = 1'b1;
          if (i_rx_valid) begin
            byte_hi_s = i_rx_data;
            csum_s    = csum_step(csum_r, i_rx_data);
            state_s   = S_DATA_LO;
          end else begin
            state_s = S_DATA_HI;
          end
        end
        S_DATA_LO: begin
          tmo_active_s = 1'b1;
          if (i_rx_valid) begin
            we_s   = 1'b1;
            data_s = {byte_hi_r, i_rx_data};
            addr_s = idx_r[ADDR_W-1:0];
            idx_s  = idx_r + 16'd1;
            csum_s = csum_step(csum_r, i_rx_data);
            if (idx_s == len_r) begin
              state_s = S_CSUM;
            end else begin
              state_s = S_DATA_HI;
            end
          end else begin
            state_s = S_DATA_LO;
          end
        end
        S_CSUM: begin
          tmo_active_s = 1'b1;
          if (i_rx_valid) begin
            if (i_rx_data == csum_r) begin
              state_s = S_DONE;
              done_s  = 1'b1;
              busy_s  = 1'b0;
            end else begin
              state_s = S_ERR;
              err_s   = 1'b1;
              code_s  = ERR_CSUM;
            end
          end else begin
            state_s = S_CSUM;
          end
        end
        S_DONE:  state_s = S_DONE;
        S_ERR:   state_s = S_ERR;
        default: state_s = S_LEN_HI;
      endcase

      // Inter-byte watchdog; it fires on the TIMEOUT-th silent cycle.
      if (tmo_active_s && !i_rx_valid) begin
        if (tmo_r == TO_LAST) begin
          state_s = S_ERR;
          err_s   = 1'b1;
          busy_s  = 1'b1;
          done_s  = 1'b0;
          code_s  = ERR_TIMEOUT;
        end else begin
          tmo_s = tmo_r + TO_W'(1);
        end
      end else begin
        tmo_s = '0;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= S_LEN_HI;
      byte_hi_r <= 8'd0;
      len_r     <= 16'd0;
      idx_r     <= 16'd0;
      csum_r    <= 8'd0;
      tmo_r     <= '0;
      we_r      <= 1'b0;
      addr_r    <= '0;
      data_r    <= 16'd0;
      busy_r    <= 1'b1;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      code_r    <= ERR_NONE;
    end else begin
      state_r   <= state_s;
      byte_hi_r <= byte_hi_s;
      len_r     <= len_s;
      idx_r     <= idx_s;
      csum_r    <= csum_s;
      tmo_r     <= tmo_s;
      we_r      <= we_s;
      addr_r    <= addr_s;
      data_r    <= data_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      err_r     <= err_s;
      code_r    <= code_s;
    end
  end

endmodule
